// File: rtl/ic_bvuge_bvashr_checker.sv
// ic_bvuge_bvashr_checker
//
// Checks a claimed witness for the predicate P(x) = (s >>>a x) >=u t.
// The shift is a W-bit arithmetic right shift, and the compare is unsigned.
// The block first tests the candidate (cand). If the candidate fails, it
// searches x = 0 .. 2^W-1 one value per cycle. It reports:
//   ok    - the candidate itself satisfies P
//   ic    - some x satisfies P (the invertibility condition)
//   x_out - the candidate or the first hit, or 0 when no x exists
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   in_valid / in_ready  request handshake (ready only in IDLE)
//   s, t, cand           shifted operand, lower bound, candidate witness
//   out_valid/out_ready  result handshake (valid only in DONE)
//   ok, ic, x_out        result, held stable while out_valid=1
//
// state  | meaning
// IDLE   | waiting for a request, in_ready=1
// CHECK  | evaluating P(cand) on the captured operands
// SEARCH | evaluating P(index), one index per cycle, ascending
// DONE   | result presented, waiting for out_ready
module ic_bvuge_bvashr_checker #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] s,
    input  logic [W-1:0] t,
    input  logic [W-1:0] cand,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         ok,
    output logic         ic,
    output logic [W-1:0] x_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        SEARCH = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [W-1:0] IDX_MAX = {W{1'b1}};

    state_t       state, state_n;
    logic [W-1:0] s_q, t_q, cand_q, s_n, t_n, cand_n;
    logic [W-1:0] index, index_n;
    logic         ok_q, ic_q, ok_n, ic_n;
    logic [W-1:0] x_q, x_n;
    logic         p_cand, p_index;

    // Shift amounts of W or more fill the result with the sign bit. The
    // case is written out explicitly so the behaviour does not rest on how
    // a tool treats an oversized shift count.
    function automatic logic pred(input logic [W-1:0] sv,
                                  input logic [W-1:0] tv,
                                  input logic [W-1:0] xv);
        logic [W-1:0] sh;
        if (32'(xv) >= W)
            sh = {W{sv[W-1]}};
        else
            sh = W'($signed(sv) >>> xv);
        return sh >= tv;
    endfunction

    assign p_cand  = pred(s_q, t_q, cand_q);
    assign p_index = pred(s_q, t_q, index);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            s_q    <= '0;
            t_q    <= '0;
            cand_q <= '0;
            index  <= '0;
            ok_q   <= 1'b0;
            ic_q   <= 1'b0;
            x_q    <= '0;
        end else begin
            state  <= state_n;
            s_q    <= s_n;
            t_q    <= t_n;
            cand_q <= cand_n;
            index  <= index_n;
            ok_q   <= ok_n;
            ic_q   <= ic_n;
            x_q    <= x_n;
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s_q;
        t_n     = t_q;
        cand_n  = cand_q;
        index_n = index;
        ok_n    = ok_q;
        ic_n    = ic_q;
        x_n     = x_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    s_n     = s;
                    t_n     = t;
                    cand_n  = cand;
                    index_n = '0;
                    ok_n    = 1'b0;
                    ic_n    = 1'b0;
                    x_n     = '0;
                    state_n = CHECK;
                end
            end
            CHECK: begin
                if (p_cand) begin
                    ok_n    = 1'b1;
                    ic_n    = 1'b1;
                    x_n     = cand_q;
                    state_n = DONE;
                end else begin
                    ok_n    = 1'b0;
                    index_n = '0;
                    state_n = SEARCH;
                end
            end
            SEARCH: begin
                if (p_index) begin
                    ic_n    = 1'b1;
                    x_n     = index;
                    state_n = DONE;
                end else if (index == IDX_MAX) begin
                    // The last index failed. The search ends here, and the
                    // index stays at the maximum instead of wrapping to 0.
                    ic_n    = 1'b0;
                    x_n     = '0;
                    state_n = DONE;
                end else begin
                    index_n = index + 1'b1;
                end
            end
            DONE: begin
                if (out_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign ok        = ok_q;
    assign ic        = ic_q;
    assign x_out     = x_q;

endmodule

// File: tb/tb_ic_bvuge_bvashr_checker.sv
// Directed testbench for ic_bvuge_bvashr_checker with W=4.
// Latency is counted inclusively: an accept edge followed by out_valid
// rising on the next edge counts as 2 cycles.
module tb_ic_bvuge_bvashr_checker;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] s, t, cand;
    logic         out_valid;
    logic         out_ready;
    logic         ok, ic;
    logic [W-1:0] x_out;

    int errors = 0;
    int checks = 0;

    ic_bvuge_bvashr_checker #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .t(t), .cand(cand),
        .out_valid(out_valid), .out_ready(out_ready),
        .ok(ok), .ic(ic), .x_out(x_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and hold out_ready low until the result appears.
    // Then check the latency and the result, release the result, and
    // confirm the return to IDLE.
    task automatic run_req(input string tag,
                           input logic [W-1:0] sv, input logic [W-1:0] tv, input logic [W-1:0] cv,
                           input logic eok, input logic eic, input logic [W-1:0] ex, input int elat);
        int n;
        @(negedge clk);
        chk({tag, ".in_ready"}, in_ready, 1);
        in_valid = 1; s = sv; t = tv; cand = cv;
        @(negedge clk);
        in_valid = 0; s = '0; t = '0; cand = '0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, n + 1, elat);
        chk({tag, ".ok"}, ok, eok);
        chk({tag, ".ic"}, ic, eic);
        chk({tag, ".x_out"}, x_out, ex);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk({tag, ".release_idle"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        int n;
        rst = 1; in_valid = 0; out_ready = 0; s = '0; t = '0; cand = '0;
        #1;
        chk("reset.in_ready", in_ready, 1);
        chk("reset.outs", {out_valid, ok, ic, x_out}, 0);
        @(negedge clk); @(negedge clk);
        rst = 0;

        // Candidate passes: 1000 >>>a 1 = 1100 >= 1100.
        run_req("pass", 4'b1000, 4'b1100, 4'b0001, 1, 1, 4'b0001, 2);
        // Candidate fails (0100>>>3=0), search hits at j=0.
        run_req("hit0", 4'b0100, 4'b0011, 4'b0011, 0, 1, 4'b0000, 3);
        // Negative s: 1000,1100 fail vs 1110; j=2 gives 1110 -> hit at j=2.
        run_req("hit2", 4'b1000, 4'b1110, 4'b0000, 0, 1, 4'b0010, 5);
        // Shift count >= W fills with the sign bit: 1010 -> 1111 >= 1111.
        run_req("bigsh", 4'b1010, 4'b1111, 4'b0100, 1, 1, 4'b0100, 2);
        // t=0 always passes.
        run_req("t0", 4'b0000, 4'b0000, 4'b1111, 1, 1, 4'b1111, 2);

        // No witness: the index runs 0..15 once, and out_valid rises at 18.
        @(negedge clk);
        in_valid = 1; s = 4'b0001; t = 4'b0010; cand = 4'b0000;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            chk("nowit.index", dut.index, k);
            chk("nowit.not_valid", out_valid, 0);
            @(negedge clk);
        end
        chk("nowit.valid_at_18", out_valid, 1);
        chk("nowit.result", {ok, ic, x_out}, 0);
        chk("nowit.no_wrap", dut.index, 4'hF);

        // Backpressure: hold the result for 5 cycles while in_valid pulses.
        for (int k = 0; k < 5; k++) begin
            in_valid = (k % 2 == 0); s = 4'b0111; t = 4'b0000; cand = 4'b0101;
            @(negedge clk);
            chk("bp.hold", {out_valid, in_ready, ok, ic, x_out}, {1'b1, 1'b0, 1'b0, 1'b0, 4'b0000});
        end
        // Release with in_valid still high: no bypass accept on the same edge.
        in_valid = 1; out_ready = 1;
        @(negedge clk);
        out_ready = 0; in_valid = 0;
        chk("bp.release", {out_valid, in_ready}, 2'b01);

        // Reset in the middle of a search, at index 7.
        @(negedge clk);
        in_valid = 1; s = 4'b0001; t = 4'b0010; cand = 4'b0000;
        @(negedge clk);
        in_valid = 0;
        n = 0;
        while (!(dut.index == 4'd7 && !in_ready && !out_valid) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid.reached7", dut.index, 7);
        #1 rst = 1;
        #1;
        chk("rst_mid.in_ready", in_ready, 1);
        chk("rst_mid.outs", {out_valid, ok, ic, x_out}, 0);
        chk("rst_mid.index", dut.index, 0);
        @(negedge clk);
        rst = 0;
        run_req("after_rst", 4'b0110, 4'b0000, 4'b1010, 1, 1, 4'b1010, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ic_bvuge_bvashr_checker.md
IC_BVUGE_BVASHR_CHECKER -- requirements
Module: ic_bvuge_bvashr_checker

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the bit-vector width; legal range 2..8.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-003 The block SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1: request present.
REQ-005 The block SHALL have port in_ready, output, 1: block can accept a request.
REQ-006 The block SHALL have port s, input, W: shifted operand, two's complement.
REQ-007 The block SHALL have port t, input, W: unsigned lower bound.
REQ-008 The block SHALL have port cand, input, W: claimed Skolem witness for x.
REQ-009 The block SHALL have port out_valid, output, 1: result present.
REQ-010 The block SHALL have port out_ready, input, 1: consumer accepts result.
REQ-011 The block SHALL have port ok, output, 1: cand satisfies the predicate.
REQ-012 The block SHALL have port ic, output, 1: invertibility condition; at least one x satisfies the predicate.
REQ-013 The block SHALL have port x_out, output, W: witness reported with the result.

Function
REQ-014 The predicate SHALL be P(x) = (s >>>a x) >=u t, where >>>a is W-bit arithmetic right shift and >=u is unsigned compare.
REQ-015 For shift amounts x >= W, s >>>a x SHALL equal W copies of s[W-1].
REQ-016 The FSM SHALL have four states: IDLE, CHECK, SEARCH, DONE; reset state IDLE.
REQ-017 in_ready SHALL be 1 only in IDLE; a request is accepted on an edge where in_valid and in_ready are both 1.
REQ-018 On accept, s, t and cand SHALL be registered, and the FSM SHALL go IDLE->CHECK; later input changes have no effect until the next accept.
REQ-019 In CHECK, one cycle: if P(cand)=1 -> DONE with ok=1, ic=1, x_out=cand; else -> SEARCH with index=0, ok latched 0.
REQ-020 In SEARCH, index SHALL be evaluated one value per cycle in ascending order, 0..2^W-1.
REQ-021 On the first index j with P(j)=1, the FSM SHALL go to DONE with ic=1 and x_out=j.
REQ-022 If index 2^W-1 fails, the FSM SHALL go to DONE with ic=0 and x_out=0; the index counter SHALL NOT wrap into a second pass.
REQ-023 Latency from the accept edge to the out_valid rising edge SHALL be: 2 cycles on a CHECK pass; 3+j cycles on a SEARCH hit at j; 2+2^W cycles on no hit.
REQ-024 out_valid SHALL be 1 only in DONE; ok, ic and x_out SHALL be held stable while out_valid=1 and out_ready=0.
REQ-025 DONE->IDLE SHALL occur on an edge with out_ready=1; a new request SHALL NOT be accepted on that same edge (no bypass).
REQ-026 The block SHALL hold no more than one request in flight; in_valid outside IDLE is ignored.
REQ-027 When t=0, P SHALL hold for every x, so CHECK always passes.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, in_ready=1, out_valid=0, ok=0, ic=0, x_out=0, and clear the index and captured operands.
REQ-029 Reset asserted in CHECK, SEARCH or DONE SHALL abort the request with no result emitted; the first accept after rst falls SHALL start clean.

Verification (W=4)
REQ-030 Pass: s=1000, t=1100, cand=0001 -> out_valid 2 cycles after accept; ok=1, ic=1, x_out=0001.
REQ-031 Fail with hit: s=0100, t=0011, cand=0011 -> search hits j=0 at 3 cycles; ok=0, ic=1, x_out=0000.
REQ-032 No witness: s=0001, t=0010, cand=0000 -> 18 cycles; ok=0, ic=0, x_out=0000; the index visits all 16 values exactly once.
REQ-033 Backpressure: out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored; release -> IDLE next edge.
REQ-034 Reset mid-SEARCH at index 7 -> immediate IDLE with all outputs 0; next request (t=0, cand=1010) -> ok=1, x_out=1010 after 2 cycles.
